// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter.
package vram_arb_pkg;

  localparam int unsigned VRAM_ADDR_W = 13;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_DONE} arb_state_t;

  // Enumerator values double as bit positions in the request/grant vectors.
  typedef enum logic [1:0] {GNT_LCD, GNT_CPU, GNT_DMA} arb_gnt_t;

  function automatic arb_gnt_t gnt_from_onehot(input logic [2:0] oh);
    if (oh[GNT_DMA]) return GNT_DMA;
    if (oh[GNT_CPU]) return GNT_CPU;
    return GNT_LCD;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester, VRAM and statistics signals of the VRAM arbiter.
// Statistics signals exist only when VRAM_ARB_STATS_EN is defined.
interface vram_arbiter_if #(
  parameter int unsigned ADDR_W = vram_arb_pkg::VRAM_ADDR_W
);
  logic              lcd_req;
  logic [ADDR_W-1:0] lcd_addr;
  logic              lcd_ack;
  logic [7:0]        lcd_data;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic              cpu_ack;
  logic [7:0]        cpu_dout;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [7:0]        dma_din;
  logic              dma_ack;
  logic [7:0]        dma_dout;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] lcd_grants;
  logic [15:0] cpu_grants;
  logic [15:0] dma_grants;
  logic [7:0]  dma_promotions;

  modport master (
    output lcd_req, lcd_addr, cpu_req, cpu_we, cpu_addr, cpu_din,
           dma_req, dma_we, dma_addr, dma_din, mem_dout,
    input  lcd_ack, lcd_data, cpu_ack, cpu_dout, dma_ack, dma_dout,
           mem_addr, mem_we, mem_din,
           lcd_grants, cpu_grants, dma_grants, dma_promotions
  );
  modport slave (
    input  lcd_req, lcd_addr, cpu_req, cpu_we, cpu_addr, cpu_din,
           dma_req, dma_we, dma_addr, dma_din, mem_dout,
    output lcd_ack, lcd_data, cpu_ack, cpu_dout, dma_ack, dma_dout,
           mem_addr, mem_we, mem_din,
           lcd_grants, cpu_grants, dma_grants, dma_promotions
  );
`else
  modport master (
    output lcd_req, lcd_addr, cpu_req, cpu_we, cpu_addr, cpu_din,
           dma_req, dma_we, dma_addr, dma_din, mem_dout,
    input  lcd_ack, lcd_data, cpu_ack, cpu_dout, dma_ack, dma_dout,
           mem_addr, mem_we, mem_din
  );
  modport slave (
    input  lcd_req, lcd_addr, cpu_req, cpu_we, cpu_addr, cpu_din,
           dma_req, dma_we, dma_addr, dma_din, mem_dout,
    output lcd_ack, lcd_data, cpu_ack, cpu_dout, dma_ack, dma_dout,
           mem_addr, mem_we, mem_din
  );
`endif

endinterface

// File: rtl/vram_arb_prio.sv
// Fixed-priority picker: LCD > CPU > DMA, or LCD > DMA > CPU when promote is set.
module vram_arb_prio
  import vram_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic       promote,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req[GNT_LCD]) begin
      gnt[GNT_LCD] = 1'b1;
    end else if (promote && req[GNT_DMA]) begin
      gnt[GNT_DMA] = 1'b1;
    end else if (req[GNT_CPU]) begin
      gnt[GNT_CPU] = 1'b1;
    end else if (req[GNT_DMA]) begin
      gnt[GNT_DMA] = 1'b1;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Serializes LCD, CPU and DMA accesses onto the single-port VRAM.
// Define VRAM_ARB_STATS_EN to add grant/promotion counters.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = VRAM_ADDR_W,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce,
  vram_arbiter_if.slave  bus
);

  localparam int unsigned LatW    = $clog2(RD_LAT + 1);
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  arb_state_t          state_q;
  arb_gnt_t            gnt_q;
  logic                acc_we_q;
  logic [LatW-1:0]     lat_cnt_q;
  logic [StarveW-1:0]  starve_cnt_q;

  logic [2:0]          req;
  logic [2:0]          gnt_oh;
  logic                promote;
  arb_gnt_t            win;
  logic [ADDR_W-1:0]   win_addr;
  logic                win_we;
  logic [7:0]          win_din;

  assign req     = {bus.dma_req, bus.cpu_req, bus.lcd_req};
  assign promote = (starve_cnt_q == StarveW'(STARVE_LIMIT));
  assign win     = gnt_from_onehot(gnt_oh);

  vram_arb_prio u_prio (
    .req     (req),
    .promote (promote),
    .gnt     (gnt_oh)
  );

  // LCD is read-only, so its write enable and data are tied off.
  always_comb begin
    win_addr = bus.lcd_addr;
    win_we   = 1'b0;
    win_din  = '0;
    case (win)
      GNT_CPU: begin
        win_addr = bus.cpu_addr;
        win_we   = bus.cpu_we;
        win_din  = bus.cpu_din;
      end
      GNT_DMA: begin
        win_addr = bus.dma_addr;
        win_we   = bus.dma_we;
        win_din  = bus.dma_din;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      gnt_q        <= GNT_LCD;
      acc_we_q     <= 1'b0;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      bus.mem_addr <= '0;
      bus.mem_we   <= 1'b0;
      bus.mem_din  <= '0;
      bus.lcd_ack  <= 1'b0;
      bus.cpu_ack  <= 1'b0;
      bus.dma_ack  <= 1'b0;
      bus.lcd_data <= '0;
      bus.cpu_dout <= '0;
      bus.dma_dout <= '0;
`ifdef VRAM_ARB_STATS_EN
      bus.lcd_grants     <= '0;
      bus.cpu_grants     <= '0;
      bus.dma_grants     <= '0;
      bus.dma_promotions <= '0;
`endif
    end else begin
      // Acks are cleared every clk so they stay one clk wide even when ce is low.
      bus.lcd_ack <= 1'b0;
      bus.cpu_ack <= 1'b0;
      bus.dma_ack <= 1'b0;
      if (ce) begin
        case (state_q)
          ARB_IDLE: begin
            if (!bus.dma_req || win == GNT_DMA) begin
              starve_cnt_q <= '0;
            end else if (|req && !promote) begin
              starve_cnt_q <= starve_cnt_q + StarveW'(1);
            end
            if (|req) begin
              gnt_q        <= win;
              acc_we_q     <= win_we;
              lat_cnt_q    <= LatW'(RD_LAT);
              bus.mem_addr <= win_addr;
              bus.mem_we   <= win_we;
              bus.mem_din  <= win_din;
              state_q      <= ARB_ACCESS;
`ifdef VRAM_ARB_STATS_EN
              case (win)
                GNT_LCD: bus.lcd_grants <= bus.lcd_grants + 16'd1;
                GNT_CPU: bus.cpu_grants <= bus.cpu_grants + 16'd1;
                default: bus.dma_grants <= bus.dma_grants + 16'd1;
              endcase
              // A promotion only decides the grant when CPU would otherwise have won.
              if (win == GNT_DMA && promote && bus.cpu_req && bus.dma_promotions != 8'hFF) begin
                bus.dma_promotions <= bus.dma_promotions + 8'd1;
              end
`endif
            end
          end
          ARB_ACCESS: begin
            bus.mem_we <= 1'b0;
            if (acc_we_q) begin
              state_q <= ARB_DONE;
            end else if (lat_cnt_q == LatW'(1)) begin
              case (gnt_q)
                GNT_LCD: bus.lcd_data <= bus.mem_dout;
                GNT_CPU: bus.cpu_dout <= bus.mem_dout;
                default: bus.dma_dout <= bus.mem_dout;
              endcase
              state_q <= ARB_DONE;
            end else begin
              lat_cnt_q <= lat_cnt_q - LatW'(1);
            end
          end
          ARB_DONE: begin
            case (gnt_q)
              GNT_LCD: bus.lcd_ack <= 1'b1;
              GNT_CPU: bus.cpu_ack <= 1'b1;
              default: bus.dma_ack <= 1'b1;
            endcase
            state_q <= ARB_IDLE;
          end
          default: state_q <= ARB_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Arbitrates the single-port 8 KB VRAM between three requesters:
- LCD field-buffer fetch (real-time)
- CPU bus
- LCD DMA engine

It serializes accesses, drives the VRAM port and returns read data through a req/ack handshake. It sits between the CPU bus decode, the DMA block, the lcd scanout fetch and the VRAM instance.

Parameters:
ADDR_W, 13, VRAM address width (8 KB).
RD_LAT, 1, VRAM read latency in ce cycles (1..3).
STARVE_LIMIT, 4, number of consecutive grants lost by a pending DMA request before DMA is promoted above CPU.

Ports:
clk  in  1  system clock (clk_sys)
reset  in  1  synchronous, active-high reset
ce  in  1  clock enable; all state advances only on clk edges with ce=1
lcd_req  in  1  LCD read request, held until lcd_ack
lcd_addr  in  ADDR_W  LCD read address
lcd_ack  out  1  one-clk pulse; lcd_data valid
lcd_data  out  8  LCD read data, held until next LCD ack
cpu_req  in  1  CPU request, held until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_din  in  8  CPU write data
cpu_ack  out  1  one-clk pulse
cpu_dout  out  8  CPU read data, held until next CPU read ack
dma_req  in  1  DMA request, held until dma_ack
dma_we  in  1  1=write, 0=read
dma_addr  in  ADDR_W  DMA address
dma_din  in  8  DMA write data
dma_ack  out  1  one-clk pulse
dma_dout  out  8  DMA read data, held until next DMA read ack
mem_addr  out  ADDR_W  VRAM address (registered)
mem_we  out  1  VRAM write enable (registered)
mem_din  out  8  VRAM write data (registered)
mem_dout  in  8  VRAM read data, valid RD_LAT ce cycles after mem_addr

Behaviour:
- Reset (synchronous, active-high; also aborts any in-flight access with no ack):
  - state=IDLE, all acks 0, mem_we 0, mem_addr 0, mem_din 0.
  - lcd_data/cpu_dout/dma_dout cleared to 0; starve_cnt 0.
- States: IDLE, ACCESS, DONE.
- IDLE, on ce with any req: select a winner, latch grant, drive mem_addr/mem_we/mem_din from the winner; go to ACCESS with lat_cnt=RD_LAT.
  - mem_we is forced 0 for LCD.
- ACCESS, on ce:
  - mem_we <= 0.
  - Write: go to DONE immediately.
  - Read: decrement lat_cnt; at lat_cnt==1 capture mem_dout into the winner's data register and go to DONE.
- DONE, on ce: pulse the winner's ack for exactly one clk; return to IDLE.
  - Back-to-back grants are therefore spaced by at least 3 ce cycles (write) or 2+RD_LAT (read).
- Priority:
  - Default order is LCD > CPU > DMA.
  - If starve_cnt==STARVE_LIMIT, order becomes LCD > DMA > CPU.
- starve_cnt (saturating, width clog2(STARVE_LIMIT+1)):
  - Increments on each IDLE grant to another requester while dma_req=1.
  - Clears on a DMA grant or when dma_req=0 in IDLE.
- Requester rules:
  - req/addr/we/din must stay stable until ack.
  - If req drops mid-access, the access still completes and the ack still pulses.
  - req sampled high in the same cycle as its own ack is treated as a new request.
- Simultaneous requests: resolved only in IDLE. Requests arriving during ACCESS/DONE wait.
- Outputs are all registered; no combinational path from req to mem_* or ack.
- With ce low, state, mem_* and data registers hold; ack pulses stay one clk wide.

Optional Feature:
Macro VRAM_ARB_STATS_EN.
- Defined: adds outputs lcd_grants, cpu_grants, dma_grants (each 16-bit, wrapping) and dma_promotions (8-bit, saturating at 255). These count grants and the number of times the starvation promotion decided a grant. All clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package vram_arb_pkg holds:
  - typedef enum {ARB_IDLE, ARB_ACCESS, ARB_DONE} arb_state_t
  - typedef enum {GNT_LCD, GNT_CPU, GNT_DMA} arb_gnt_t
  - localparam VRAM_ADDR_W=13
- One sub-module, vram_arb_prio: a combinational priority picker with inputs req[2:0] and promote, and outputs the one-hot grant.

Test Plan:
- Reset, then CPU write addr 0x0123 data 0xA5 with ce=1 every clk -> mem_we=1 for one clk with mem_addr=0x0123 and mem_din=0xA5; cpu_ack 2 ce cycles later. A following CPU read of 0x0123 returns cpu_dout=0xA5 with RD_LAT=1.
- lcd_req, cpu_req and dma_req all raised in the same clk -> grant order LCD, CPU, DMA. Acks are never concurrent; each ack is one clk wide.
- cpu_req held continuously while dma_req is pending, STARVE_LIMIT=4 -> the DMA grant occurs after 4 CPU grants; starve_cnt returns to 0.
- ce asserted every 3rd clk during a DMA read of 0x1FFF -> completion is stretched proportionally; dma_ack is one clk wide; mem_addr is stable throughout.
- reset asserted in ACCESS during a CPU write -> no cpu_ack; next cycle state=IDLE, mem_we=0; a fresh request completes normally.
- LCD drops lcd_req one clk after grant -> the access completes, lcd_ack still pulses once, and no second LCD access occurs.
